// File: rtl/asm_sched_pkg.sv
// Shared types for the sum-engine job scheduler: FSM state encoding and default datapath widths.
package asm_sched_pkg;

  localparam int unsigned DefNw = 32;
  localparam int unsigned DefSw = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp,
    StDrain
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdW-1:0]  idx_o,
  output logic            any_o
);

  logic [IdW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IdW'((32'(ptr_i) + off) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/asm_job_scheduler.sv
// Shares one sum-of-1..N engine among NREQ requesters: round-robin grant, launch, watchdog-guarded
// wait, tagged one-cycle response, then drain until the engine drops done.
module asm_job_scheduler
  import asm_sched_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned NW      = DefNw,
  parameter  int unsigned SW      = DefSw,
  parameter  int unsigned TIMEOUT = 4096,
  localparam int unsigned IdW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned WdW     = $clog2(TIMEOUT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ*NW-1:0] req_n_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             rsp_valid_o,
  output logic [IdW-1:0]   rsp_id_o,
  output logic [SW-1:0]    rsp_sum_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic             eng_go_o,
  output logic [NW-1:0]    eng_n_o,
  input  logic             eng_done_i,
  input  logic [SW-1:0]    eng_sum_i
);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [NW-1:0]   eng_n_q, eng_n_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [IdW-1:0]  rsp_id_q, rsp_id_d;
  logic [SW-1:0]   rsp_sum_q, rsp_sum_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IdW-1:0]  arb_idx;
  logic            arb_any;
  logic [NW-1:0]   sel_n;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    sel_n = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_idx == IdW'(i)) sel_n = req_n_i[i*NW +: NW];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    eng_n_d   = eng_n_q;
    gnt_d     = gnt_q;
    wd_d      = wd_q;
    rsp_id_d  = rsp_id_q;
    rsp_sum_d = rsp_sum_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          id_d    = arb_idx;
          eng_n_d = sel_n;
          gnt_d   = arb_gnt;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done takes priority over a watchdog expiring in the same cycle.
        if (eng_done_i) begin
          rsp_id_d  = id_q;
          rsp_sum_d = eng_sum_i;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          rsp_id_d  = id_q;
          rsp_sum_d = '0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StResp: begin
        gnt_d   = '0;
        ptr_d   = (id_q == IdW'(NREQ - 1)) ? '0 : id_q + IdW'(1);
        state_d = StDrain;
      end
      StDrain: begin
        // Hold off until the engine drops done so a stale level cannot end the next job.
        if (!eng_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      id_q      <= '0;
      eng_n_q   <= '0;
      gnt_q     <= '0;
      wd_q      <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      eng_n_q   <= eng_n_d;
      gnt_q     <= gnt_d;
      wd_q      <= wd_d;
      rsp_id_q  <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != StIdle);
  assign eng_go_o    = (state_q == StLaunch);
  assign eng_n_o     = eng_n_q;

endmodule

// File: tb/tb_asm_job_scheduler.sv
// Directed bench for asm_job_scheduler with a behavioural sum engine whose latency, done-hold
// time and stuck mode are adjustable per test.
module tb_asm_job_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NW   = 32;
  localparam int unsigned SW   = 64;
  localparam int unsigned TO   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*NW-1:0] req_n = '0;
  logic [NREQ-1:0] gnt;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [SW-1:0]   rsp_sum;
  logic            rsp_err;
  logic            busy;
  logic            eng_go;
  logic [NW-1:0]   eng_n;
  logic            eng_done = 1'b0;
  logic [SW-1:0]   eng_sum = '0;

  int checks = 0;
  int errors = 0;

  asm_job_scheduler #(
    .NREQ    (NREQ),
    .NW      (NW),
    .SW      (SW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_n_i     (req_n),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .eng_go_o    (eng_go),
    .eng_n_o     (eng_n),
    .eng_done_i  (eng_done),
    .eng_sum_i   (eng_sum)
  );

  always #5 clk = ~clk;

  // Behavioural engine: done rises eng_lat cycles after go, stays high eng_hold+1 cycles.
  int eng_lat   = 3;
  int eng_hold  = 2;
  bit eng_stuck = 1'b0;
  int eng_cnt   = 0;
  int eng_hc    = 0;

  function automatic logic [SW-1:0] tri_sum(input logic [NW-1:0] n);
    logic [SW-1:0] s;
    s = '0;
    for (int unsigned i = 1; i <= n; i++) s = s + SW'(i);
    return s;
  endfunction

  always @(posedge clk) begin
    if (eng_go) begin
      eng_done <= 1'b0;
      eng_cnt  <= eng_lat;
      eng_sum  <= tri_sum(eng_n);
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_stuck) begin
        eng_done <= 1'b1;
        eng_hc   <= eng_hold;
      end
    end else if (eng_done) begin
      if (eng_hc == 0) eng_done <= 1'b0;
      else eng_hc <= eng_hc - 1;
    end
  end

  // Monitors
  int            go_cnt = 0;
  int            rsp_cnt = 0;
  int            go_while_done = 0;
  logic [NREQ-1:0] gnt_at_go = '0;
  logic [NW-1:0] n_at_go = '0;

  always @(posedge clk) begin
    if (!rst && eng_go) begin
      go_cnt    <= go_cnt + 1;
      gnt_at_go <= gnt;
      n_at_go   <= eng_n;
      if (eng_done) go_while_done <= go_while_done + 1;
    end
    if (!rst && rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [NW-1:0] n);
    req_n[i*NW +: NW] = n;
    req[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_go(input int budget, output bit ok);
    int c;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < budget) begin
      @(negedge clk);
      c++;
      if (eng_go) ok = 1'b1;
    end
  endtask

  typedef struct {
    bit              do_rst;
    logic [NREQ-1:0] set;
    logic [NW-1:0]   n [NREQ];
    int unsigned     exp_id;
    logic [SW-1:0]   exp_sum;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit r, input logic [3:0] s, input int n0, input int n1,
                         input int n2, input int n3, input int unsigned id, input longint sum);
    vec_t v;
    v.do_rst  = r;
    v.set     = s;
    v.n[0]    = NW'(n0);
    v.n[1]    = NW'(n1);
    v.n[2]    = NW'(n2);
    v.n[3]    = NW'(n3);
    v.exp_id  = id;
    v.exp_sum = SW'(sum);
    vecs.push_back(v);
  endtask

  initial begin
    bit ok;
    int cyc;
    int g0;
    int r0;
    logic [NW-1:0] exp_n;

    // One response per entry; the bench drops the expected winner's req after each response.
    add_vec(1, 4'b0001, 50, 0, 0, 0, 0, 1275);
    add_vec(1, 4'b0101, 10, 0, 100, 0, 0, 55);
    add_vec(0, 4'b0000, 0, 0, 0, 0, 2, 5050);
    add_vec(1, 4'b1111, 1, 2, 3, 4, 0, 1);
    add_vec(0, 4'b0001, 1, 0, 0, 0, 1, 3);
    add_vec(0, 4'b0010, 0, 2, 0, 0, 2, 6);
    add_vec(0, 4'b0100, 0, 0, 3, 0, 3, 10);
    add_vec(0, 4'b1000, 0, 0, 0, 4, 0, 1);
    add_vec(0, 4'b0000, 0, 0, 0, 0, 1, 3);
    add_vec(0, 4'b0000, 0, 0, 0, 0, 2, 6);
    add_vec(0, 4'b0000, 0, 0, 0, 0, 3, 10);
    add_vec(1, 4'b0001, 0, 0, 0, 0, 0, 0);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_go", eng_go, 0);
    chk("rst_eng_n", eng_n, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      if (vecs[k].do_rst) do_reset();
      for (int i = 0; i < NREQ; i++)
        if (vecs[k].set[i]) set_req(i, vecs[k].n[i]);
      exp_n = req_n[vecs[k].exp_id*NW +: NW];
      g0 = go_cnt;
      wait_rsp(200, ok, cyc);
      chk($sformatf("v%0d_rsp_seen", k), ok, 1);
      chk($sformatf("v%0d_id", k), rsp_id, vecs[k].exp_id);
      chk($sformatf("v%0d_sum", k), rsp_sum, vecs[k].exp_sum);
      chk($sformatf("v%0d_err", k), rsp_err, 0);
      chk($sformatf("v%0d_go_pulses", k), go_cnt - g0, 1);
      chk($sformatf("v%0d_gnt", k), gnt_at_go, 64'(1) << vecs[k].exp_id);
      chk($sformatf("v%0d_eng_n", k), n_at_go, exp_n);
      req[vecs[k].exp_id] = 1'b0;
    end
    repeat (10) @(negedge clk);

    // Latency: done in cycle 4 after LAUNCH -> rsp_valid 5 cycles after LAUNCH
    do_reset();
    set_req(0, 50);
    wait_go(20, ok);
    chk("lat_go_seen", ok, 1);
    wait_rsp(50, ok, cyc);
    chk("lat_cycles", cyc, 5);
    chk("lat_sum", rsp_sum, 1275);
    req = '0;
    repeat (6) @(negedge clk);

    // Watchdog: engine never completes
    eng_stuck = 1'b1;
    set_req(0, 5);
    wait_go(20, ok);
    chk("to_go_seen", ok, 1);
    wait_rsp(TO + 20, ok, cyc);
    chk("to_cycles", cyc, TO + 1);
    chk("to_err", rsp_err, 1);
    chk("to_sum", rsp_sum, 0);
    req = '0;
    repeat (2) @(negedge clk);
    chk("to_back_idle", busy, 0);
    eng_stuck = 1'b0;

    // Reset during WAIT: no response, outputs back to reset values
    eng_lat = 20;
    set_req(2, 50);
    wait_go(20, ok);
    repeat (3) @(negedge clk);
    r0  = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", rsp_err, 0);
    chk("mid_rst_eng_n", eng_n, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (40) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_cnt - r0, 0);
    eng_lat = 3;
    set_req(0, 50);
    wait_rsp(50, ok, cyc);
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_sum", rsp_sum, 1275);
    req = '0;
    repeat (6) @(negedge clk);

    // Withdraw req mid-job; long done hold exercises DRAIN before the next launch
    do_reset();
    eng_hold = 8;
    r0 = rsp_cnt;
    set_req(1, 7);
    wait_go(20, ok);
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    wait_rsp(50, ok, cyc);
    chk("wd_rsp_seen", ok, 1);
    chk("wd_id", rsp_id, 1);
    chk("wd_sum", rsp_sum, 28);
    set_req(2, 3);
    repeat (2) @(negedge clk);
    chk("drain_gnt_clear", gnt, 0);
    chk("drain_busy", busy, 1);
    chk("drain_no_go", eng_go, 0);
    wait_rsp(80, ok, cyc);
    chk("drain_next_id", rsp_id, 2);
    chk("drain_next_sum", rsp_sum, 6);
    req = '0;
    repeat (12) @(negedge clk);
    chk("wd_rsp_count", rsp_cnt - r0, 2);
    chk("go_while_done", go_while_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
